// File: rtl/mac_frame_arbiter.sv
// Round-robin frame arbiter: locks one requester per frame onto a registered, id-tagged MAC operand stream.
// Optional MAC_ARB_PRIO_EN: requester 0 wins every arbitration it requests; the others rotate among themselves.
module mac_frame_arbiter #(
    parameter int INT_A  = 6,
    parameter int FRAC_A = 8,
    parameter int INT_B  = 6,
    parameter int FRAC_B = 8,
    parameter int NREQ   = 4,
    parameter int IDW    = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NREQ*(INT_A+FRAC_A)-1:0]   s_a_data,
    input  logic [NREQ*(INT_B+FRAC_B)-1:0]   s_b_data,
    input  logic [NREQ-1:0]                  s_valid,
    input  logic [NREQ-1:0]                  s_last,
    output logic [NREQ-1:0]                  s_ready,
    output logic [INT_A+FRAC_A-1:0]          m_a_data,
    output logic [INT_B+FRAC_B-1:0]          m_b_data,
    output logic                             m_valid,
    output logic                             m_last,
    output logic [IDW-1:0]                   m_id,
    input  logic                             m_ready,
    output logic                             busy
);
    localparam int WA = INT_A + FRAC_A;
    localparam int WB = INT_B + FRAC_B;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic           m_valid_q, m_valid_d;
    logic           m_last_q, m_last_d;
    logic [IDW-1:0] m_id_q, m_id_d;
    logic [WA-1:0]  m_a_q, m_a_d;
    logic [WB-1:0]  m_b_q, m_b_d;

    logic [NREQ-1:0]   arb_req;
    logic [2*NREQ-1:0] arb_dbl;
    logic [NREQ-1:0]   arb_rot;
    logic [IDW-1:0]    arb_pick;
    logic              arb_found;

    logic           out_free;
    logic           accept;
    logic           sel_valid;
    logic           sel_last;
    logic [WA-1:0]  sel_a;
    logic [WB-1:0]  sel_b;

    always_comb begin
        arb_req = s_valid;
`ifdef MAC_ARB_PRIO_EN
        if (s_valid[0]) begin
            arb_req = {{(NREQ-1){1'b0}}, 1'b1};
        end
`endif
    end

    // Rotate so that bit 0 is the requester just after last_grant; the IDW-bit
    // wrap of last_grant+1 still lands on a correct rotation for every NREQ.
    always_comb begin
        arb_dbl   = {arb_req, arb_req} >> (last_grant_q + 1'b1);
        arb_rot   = arb_dbl[NREQ-1:0];
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && arb_rot[i]) begin
                arb_found = 1'b1;
                arb_pick  = IDW'((int'(last_grant_q) + 1 + i) % NREQ);
            end
        end
    end

    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];
    assign sel_a     = s_a_data[grant_q*WA +: WA];
    assign sel_b     = s_b_data[grant_q*WB +: WB];

    assign out_free  = !m_valid_q || m_ready;
    assign accept    = (state_q == LOCKED) && sel_valid && out_free;

    always_comb begin
        s_ready = '0;
        if (state_q == LOCKED && !reset) begin
            s_ready[grant_q] = out_free;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q && !m_ready;
        m_last_d     = m_last_q;
        m_id_d       = m_id_q;
        m_a_d        = m_a_q;
        m_b_d        = m_b_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_last_d  = sel_last;
                    m_id_d    = grant_q;
                    m_a_d     = sel_a;
                    m_b_d     = sel_b;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_id_q       <= '0;
            m_a_q        <= '0;
            m_b_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_id_q       <= m_id_d;
            m_a_q        <= m_a_d;
            m_b_q        <= m_b_d;
        end
    end

    assign m_a_data = m_a_q;
    assign m_b_data = m_b_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_id     = m_id_q;
    assign busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_mac_frame_arbiter.sv
// Randomized bench for mac_frame_arbiter: frame-level reference model feeds a scoreboard queue,
// an independent monitor pops and compares every beat the DUT hands to the MAC side.
module tb_mac_frame_arbiter;
    localparam int INT_A = 6, FRAC_A = 8, INT_B = 6, FRAC_B = 8;
    localparam int NREQ = 4, IDW = 2;
    localparam int WA = INT_A + FRAC_A, WB = INT_B + FRAC_B, MAXB = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ*WA-1:0]    s_a_data;
    logic [NREQ*WB-1:0]    s_b_data;
    logic [NREQ-1:0]       s_valid, s_last, s_ready;
    logic [WA-1:0]         m_a_data;
    logic [WB-1:0]         m_b_data;
    logic                  m_valid, m_last, m_ready, busy;
    logic [IDW-1:0]        m_id;

    mac_frame_arbiter #(
        .INT_A(INT_A), .FRAC_A(FRAC_A), .INT_B(INT_B), .FRAC_B(FRAC_B),
        .NREQ(NREQ), .IDW(IDW)
    ) dut (
        .clock(clock), .reset(reset),
        .s_a_data(s_a_data), .s_b_data(s_b_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_a_data(m_a_data), .m_b_data(m_b_data),
        .m_valid(m_valid), .m_last(m_last), .m_id(m_id),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WA-1:0]  a;
        logic [WB-1:0]  b;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Requester-side frame store
    logic [WA-1:0] fa [NREQ][MAXB];
    logic [WB-1:0] fb [NREQ][MAXB];
    int            flen [NREQ];
    int            bi   [NREQ];

    logic [NREQ-1:0] mask;
    int pv, pr, prst, fixlen, phase, ncyc;

    // Reference model state
    bit              mdl_locked, mdl_full, was_rst, acc;
    int              mdl_gid, mdl_last;
    logic [NREQ-1:0] hs, exp_rdy;
    beat_t           nb;
    bit              started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_frame(input int i);
        flen[i] = (fixlen > 0) ? fixlen : int'($urandom_range(1, MAXB - 2));
        for (int k = 0; k < flen[i]; k++) begin
            if (phase == 0) begin
                fa[i][k] = WA'((k + 1) * 256);
                fb[i][k] = WB'(128);
            end else begin
                fa[i][k] = WA'($urandom);
                fb[i][k] = WB'($urandom);
            end
        end
        bi[i] = 0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int p;
        int c;
        p = -1;
`ifdef MAC_ARB_PRIO_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            c = (last + k) % NREQ;
            if (p < 0 && v[c]) p = c;
        end
        return p;
    endfunction

    // Stimulus and reference model
    initial begin
        reset = 1'b1; s_valid = '0; s_last = '0; s_a_data = '0; s_b_data = '0; m_ready = 1'b0;
        mdl_locked = 1'b0; mdl_full = 1'b0; mdl_gid = 0; mdl_last = NREQ - 1;
        hs = '0; was_rst = 1'b1;
        phase = 0; fixlen = 3; mask = '0; pv = 0; pr = 0; prst = 0; ncyc = 0;
        for (int i = 0; i < NREQ; i++) new_frame(i);
        repeat (2) @(posedge clock);
        started = 1'b1;
        for (int ph = 0; ph < 7; ph++) begin
            phase = ph;
            case (ph)
                0: begin mask = 4'b0010; fixlen = 3; pv = 100; pr = 100; prst = 0; ncyc = 30;  end
                1: begin mask = 4'b1111; fixlen = 2; pv = 100; pr = 100; prst = 0; ncyc = 60;  end
                2: begin mask = 4'b1111; fixlen = 4; pv = 100; pr = 50;  prst = 0; ncyc = 300; end
                3: begin mask = 4'b1111; fixlen = 0; pv = 50;  pr = 80;  prst = 0; ncyc = 400; end
                4: begin mask = 4'b1111; fixlen = 0; pv = 80;  pr = 70;  prst = 4; ncyc = 400; end
                5: begin mask = 4'b0011; fixlen = 1; pv = 100; pr = 100; prst = 0; ncyc = 60;  end
                default: begin mask = 4'b0000; fixlen = 0; pv = 100; pr = 100; prst = 0; ncyc = 40; end
            endcase
            for (int c = 0; c < ncyc; c++) begin
                #1;
                for (int i = 0; i < NREQ; i++) begin
                    if (was_rst) bi[i] = 0;
                    else if (hs[i]) begin
                        if (bi[i] == flen[i] - 1) new_frame(i);
                        else bi[i]++;
                    end
                end
                if (c == 0) begin
                    for (int i = 0; i < NREQ; i++)
                        if (bi[i] == 0 && !(mdl_locked && mdl_gid == i)) new_frame(i);
                end
                reset = (prst > 0) && ($urandom_range(0, 99) < prst);
                for (int i = 0; i < NREQ; i++) begin
                    s_valid[i] = (mask[i] || (mdl_locked && mdl_gid == i) || bi[i] > 0)
                                 && ($urandom_range(0, 99) < pv);
                    s_a_data[i*WA +: WA] = fa[i][bi[i]];
                    s_b_data[i*WB +: WB] = fb[i][bi[i]];
                    s_last[i] = (bi[i] == flen[i] - 1);
                end
                m_ready = !reset && ($urandom_range(0, 99) < pr);

                @(negedge clock);
                exp_rdy = '0;
                if (mdl_locked && !reset && (!mdl_full || m_ready)) exp_rdy[mdl_gid] = 1'b1;
                check("s_ready", 64'(s_ready), 64'(exp_rdy));
                check("busy", 64'(busy), 64'(mdl_locked));
                check("m_valid", 64'(m_valid), 64'(mdl_full));
                if (was_rst) begin
                    check("rst_m_a", 64'(m_a_data), 64'd0);
                    check("rst_m_b", 64'(m_b_data), 64'd0);
                    check("rst_m_id", 64'(m_id), 64'd0);
                    check("rst_m_last", 64'(m_last), 64'd0);
                end
                hs = s_valid & s_ready;
                if (reset) begin
                    mdl_locked = 1'b0; mdl_full = 1'b0; mdl_last = NREQ - 1;
                    exp_q.delete();
                end else if (!mdl_locked) begin
                    mdl_full = mdl_full && !m_ready;
                    if (|s_valid) begin
                        mdl_gid = pick(s_valid, mdl_last);
                        mdl_locked = 1'b1;
                        for (int k = 0; k < flen[mdl_gid]; k++) begin
                            nb.id   = IDW'(mdl_gid);
                            nb.a    = fa[mdl_gid][k];
                            nb.b    = fb[mdl_gid][k];
                            nb.last = (k == flen[mdl_gid] - 1);
                            exp_q.push_back(nb);
                        end
                    end
                end else begin
                    acc = s_valid[mdl_gid] && (!mdl_full || m_ready);
                    mdl_full = acc || (mdl_full && !m_ready);
                    if (acc && bi[mdl_gid] == flen[mdl_gid] - 1) begin
                        mdl_locked = 1'b0;
                        mdl_last = mdl_gid;
                    end
                end
                was_rst = reset;
                @(posedge clock);
            end
        end
        #1;
        @(negedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'({m_valid, busy}), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Output monitor: in-order beat check plus stall stability
    bit             hold = 1'b0;
    logic [WA-1:0]  p_a;
    logic [WB-1:0]  p_b;
    logic [IDW-1:0] p_id;
    logic           p_last;
    beat_t          e;

    always @(negedge clock) begin
        if (started && !reset) begin
            if (hold) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_a", 64'(m_a_data), 64'(p_a));
                check("stall_b", 64'(m_b_data), 64'(p_b));
                check("stall_id", 64'(m_id), 64'(p_id));
                check("stall_last", 64'(m_last), 64'(p_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: got id %0h a %0h, expected no beat at %0t", m_id, m_a_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_id", 64'(m_id), 64'(e.id));
                    check("beat_a", 64'(m_a_data), 64'(e.a));
                    check("beat_b", 64'(m_b_data), 64'(e.b));
                    check("beat_last", 64'(m_last), 64'(e.last));
                end
            end
            hold   = m_valid && !m_ready;
            p_a    = m_a_data;
            p_b    = m_b_data;
            p_id   = m_id;
            p_last = m_last;
        end else begin
            hold = 1'b0;
        end
    end

endmodule
